// File: rtl/fifo_rd_unpacker.sv
// ============================================================================
// Module      : fifo_rd_unpacker
// Description : Drains a wide FIFO one word at a time and unpacks each word
//               into BEAT_W beats on a valid/ready stream, counting the words
//               that drain completely. Define FIFO_UNPACK_MSB_FIRST_EN to emit
//               the most significant beat first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_unpacker #(
  parameter int DATA_W = 128,
  parameter int BEAT_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rddata,
  output logic              fifo_rden,
  output logic [BEAT_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_word_cnt
);

  localparam int NBEATS = DATA_W / BEAT_W;
  localparam int IDX_W  = $clog2(NBEATS);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NBEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_CAP  = 2'd2,
    S_SEND = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_rden;
  logic               w_rden_nxt;
  logic               r_valid;
  logic               w_valid_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [DATA_W-1:0]  r_word;
  logic [DATA_W-1:0]  w_word_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_idx_last;
  logic [BEAT_W-1:0]  w_beats [NBEATS];

  // Beat i of the held word; the slice order is the only build difference.
  generate
    for (genvar i = 0; i < NBEATS; i++) begin : g_beat
`ifdef FIFO_UNPACK_MSB_FIRST_EN
      assign w_beats[i] = r_word[(NBEATS-1-i)*BEAT_W +: BEAT_W];
`else
      assign w_beats[i] = r_word[i*BEAT_W +: BEAT_W];
`endif
    end
  endgenerate

  assign w_idx_last = (r_idx == C_LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_rden  <= 1'b0;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_word  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rden  <= w_rden_nxt;
      r_valid <= w_valid_nxt;
      r_idx   <= w_idx_nxt;
      r_word  <= w_word_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rden_nxt  = 1'b0;
    w_valid_nxt = r_valid;
    w_idx_nxt   = r_idx;
    w_word_nxt  = r_word;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      // Empty is only looked at here, so a read is never issued blind.
      S_IDLE: begin
        if (i_en && !fifo_empty) begin
          w_rden_nxt  = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        w_state_nxt = S_CAP;
      end
      S_CAP: begin
        w_word_nxt  = fifo_rddata;
        w_idx_nxt   = '0;
        w_valid_nxt = 1'b1;
        w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (r_valid && m_ready) begin
          if (w_idx_last) begin
            w_valid_nxt = 1'b0;
            w_idx_nxt   = '0;
            w_cnt_nxt   = r_cnt + 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign fifo_rden  = r_rden;
  assign m_valid    = r_valid;
  assign m_data     = w_beats[r_idx];
  assign m_last     = r_valid && w_idx_last;
  assign o_busy     = (r_state != S_IDLE);
  assign o_word_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_unpacker.sv
// ============================================================================
// Module      : tb_fifo_rd_unpacker
// Description : Scoreboard bench for fifo_rd_unpacker with a behavioural FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_unpacker;

  localparam int DATA_W = 128;
  localparam int BEAT_W = 32;
  localparam int CNT_W  = 4;
  localparam int NBEATS = DATA_W / BEAT_W;

`ifdef FIFO_UNPACK_MSB_FIRST_EN
  localparam logic [31:0] C_FIRST = 32'hDDDDDDDD;
  localparam logic [31:0] C_STALL = 32'hCCCCCCCC;
  localparam logic [31:0] C_FINAL = 32'hAAAAAAAA;
`else
  localparam logic [31:0] C_FIRST = 32'hAAAAAAAA;
  localparam logic [31:0] C_STALL = 32'hBBBBBBBB;
  localparam logic [31:0] C_FINAL = 32'hDDDDDDDD;
`endif
  localparam logic [127:0] C_WORD = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              i_en = 1'b0;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rddata = '0;
  logic              fifo_rden;
  logic [BEAT_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic              m_last;
  logic              o_busy;
  logic [CNT_W-1:0]  o_word_cnt;

  typedef struct packed {
    logic [BEAT_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t             exp_q[$];
  logic [DATA_W-1:0] fq[$];
  int                n_push = 0;
  int                n_pop = 0;
  int                n_pass = 0;
  int                n_chk = 0;
  int                rd_cnt = 0;
  int                base_rd;

  logic              prev_stall = 1'b0;
  logic              prev_last = 1'b0;
  logic              prev_rden = 1'b0;
  logic [BEAT_W-1:0] prev_data = '0;

  fifo_rd_unpacker #(
    .DATA_W(DATA_W),
    .BEAT_W(BEAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_en       (i_en),
    .fifo_empty (fifo_empty),
    .fifo_rddata(fifo_rddata),
    .fifo_rden  (fifo_rden),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .o_busy     (o_busy),
    .o_word_cnt (o_word_cnt)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (n_push == n_pop);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Load a word into the FIFO and queue its expected beats.
  task automatic push_word(input logic [DATA_W-1:0] w);
    int slot;
    beat_t b;
    fq.push_back(w);
    n_push++;
    for (int k = 0; k < NBEATS; k++) begin
`ifdef FIFO_UNPACK_MSB_FIRST_EN
      slot = NBEATS - 1 - k;
`else
      slot = k;
`endif
      b.data = w[slot*BEAT_W +: BEAT_W];
      b.last = (k == NBEATS - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 50; i++) begin
      if (m_valid) break;
      cycles(1);
    end
    chk(name, m_valid, 1'b1);
  endtask

  task automatic wait_drain(input string name, input int left);
    for (int i = 0; i < 500; i++) begin
      if (exp_q.size() == left && !o_busy) break;
      cycles(1);
    end
    chk(name, (exp_q.size() == left) && !o_busy, 1'b1);
  endtask

  // Behavioural FIFO: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (reset && fifo_rden) begin
      if (fq.size() == 0) begin
        chk("read_while_empty", 1'b0, 1'b1);
      end else begin
        fifo_rddata <= fq.pop_front();
        n_pop++;
      end
    end
  end

  // Monitor: protocol checks and scoreboard pop on every accepted beat.
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
      prev_rden  = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", m_valid, 1'b1);
        chk("hold_data", m_data, prev_data);
        chk("hold_last", m_last, prev_last);
      end
      if (fifo_rden) begin
        rd_cnt++;
        chk("rden_single_cycle", prev_rden, 1'b0);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", m_data, 'x);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", m_data, e.data);
          chk("beat_last", m_last, e.last);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      prev_rden  = fifo_rden;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cycles(2);
    chk("rst_rden", fifo_rden, 1'b0);
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_last", m_last, 1'b0);
    chk("rst_data", m_data, 32'h0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_cnt", o_word_cnt, 4'd0);
    reset = 1'b1;
    cycles(1);

    // Single word, latency and beat order
    base_rd = rd_cnt;
    push_word(C_WORD);
    i_en = 1'b1;
    m_ready = 1'b1;
    cycles(1);
    chk("t1_rden_high", fifo_rden, 1'b1);
    chk("t1_valid_c1", m_valid, 1'b0);
    cycles(1);
    chk("t1_rden_low", fifo_rden, 1'b0);
    chk("t1_valid_c2", m_valid, 1'b0);
    chk("t1_busy", o_busy, 1'b1);
    cycles(1);
    chk("t1_valid_c3", m_valid, 1'b1);
    chk("t1_first_beat", m_data, C_FIRST);
    chk("t1_first_not_last", m_last, 1'b0);
    cycles(3);
    chk("t1_final_beat", m_data, C_FINAL);
    chk("t1_final_last", m_last, 1'b1);
    cycles(1);
    chk("t1_valid_drop", m_valid, 1'b0);
    chk("t1_cnt", o_word_cnt, 4'd1);
    chk("t1_one_read", rd_cnt - base_rd, 1);

    // Backpressure on beat 1 with a second word waiting
    push_word(C_WORD);
    wait_valid("t2_valid");
    cycles(1);
    m_ready = 1'b0;
    push_word(128'h44444444_33333333_22222222_11111111);
    base_rd = rd_cnt;
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      chk("t2_stall_data", m_data, C_STALL);
      chk("t2_stall_valid", m_valid, 1'b1);
    end
    chk("t2_no_read_stalled", rd_cnt - base_rd, 0);
    m_ready = 1'b1;
    cycles(3);
    chk("t2_idle_rden", fifo_rden, 1'b0);
    chk("t2_idle_busy", o_busy, 1'b0);
    cycles(1);
    chk("t2_next_read", fifo_rden, 1'b1);
    wait_drain("t2_drain", 0);
    chk("t2_cnt", o_word_cnt, 4'd3);

    // Empty FIFO with enable held high
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      chk("t3_rden", fifo_rden, 1'b0);
      chk("t3_busy", o_busy, 1'b0);
      chk("t3_valid", m_valid, 1'b0);
    end

    // Enable drop during beat 2 of the first of three words
    push_word(128'h0A0A0A0A_09090909_08080808_07070707);
    push_word(128'h1F1F1F1F_1E1E1E1E_1D1D1D1D_1C1C1C1C);
    push_word(128'h2B2B2B2B_2A2A2A2A_29292929_28282828);
    wait_valid("t4_valid");
    cycles(2);
    i_en = 1'b0;
    base_rd = rd_cnt;
    wait_drain("t4_word1", 2 * NBEATS);
    cycles(5);
    chk("t4_cnt_hold", o_word_cnt, 4'd4);
    chk("t4_no_read", rd_cnt - base_rd, 0);
    chk("t4_fifo_left", fq.size(), 2);
    i_en = 1'b1;
    wait_drain("t4_drain", 0);
    chk("t4_cnt", o_word_cnt, 4'd6);

    // Asynchronous reset during beat 2
    push_word(128'h55555555_66666666_77777777_88888888);
    wait_valid("t5_valid");
    cycles(2);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_valid", m_valid, 1'b0);
    chk("t5_last", m_last, 1'b0);
    chk("t5_data", m_data, 32'h0);
    chk("t5_rden", fifo_rden, 1'b0);
    chk("t5_busy", o_busy, 1'b0);
    chk("t5_cnt", o_word_cnt, 4'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      chk("t5_post_valid", m_valid, 1'b0);
      chk("t5_post_busy", o_busy, 1'b0);
    end

    // Counter wrap: 17 words through a 4-bit counter
    for (int k = 0; k < 17; k++) begin
      push_word({32'(k * 4 + 3), 32'(k * 4 + 2), 32'(k * 4 + 1), 32'(k * 4)});
    end
    wait_drain("t6_drain", 0);
    chk("t6_cnt_wrap", o_word_cnt, 4'd1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
